// File: rtl/vram_blit_pkg.sv
// vram_blit_pkg: shared types and constants for the VRAM blitter.
// State encoding, transfer modes and bus widths.
package vram_blit_pkg;

  localparam int VRAM_ADDR_W = 20;
  localparam int BUS_DATA_W  = 48;
  localparam int PIX_W       = 16;

  localparam logic MODE_FILL = 1'b0;
  localparam logic MODE_COPY = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_WR_REQ,
    ST_WR_LOW,
    ST_WR_HIGH,
    ST_NEXT,
    ST_DONE
  } blit_state_t;

  function automatic logic [BUS_DATA_W-1:0] pack_pix(
    input logic [PIX_W-1:0] p
  );
    return {{(BUS_DATA_W-PIX_W){1'b0}}, p};
  endfunction

endpackage

// File: rtl/blit_addr_gen.sv
// blit_addr_gen: source/destination pointers and remaining word count.
// Pointers wrap modulo 2^20; last flags the final word of a transfer.
module blit_addr_gen
  import vram_blit_pkg::*;
(
  input  logic                   clk_50mhz,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   step,
  input  logic [VRAM_ADDR_W-1:0] src_in,
  input  logic [VRAM_ADDR_W-1:0] dst_in,
  input  logic [VRAM_ADDR_W-1:0] len_in,
  output logic [VRAM_ADDR_W-1:0] dst,
  output logic [VRAM_ADDR_W-1:0] src_nxt,
  output logic [VRAM_ADDR_W-1:0] dst_nxt,
  output logic                   last
);

  logic [VRAM_ADDR_W-1:0] src;
  logic [VRAM_ADDR_W-1:0] remaining;

  assign src_nxt = src + VRAM_ADDR_W'(1);
  assign dst_nxt = dst + VRAM_ADDR_W'(1);
  assign last    = (remaining == VRAM_ADDR_W'(1));

  // load a new command or advance one word
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      src       <= '0;
      dst       <= '0;
      remaining <= '0;
    end else if (load) begin
      src       <= src_in;
      dst       <= dst_in;
      remaining <= len_in;
    end else if (step) begin
      src       <= src_nxt;
      dst       <= dst_nxt;
      remaining <= remaining - VRAM_ADDR_W'(1);
    end
  end

endmodule

// File: rtl/vram_blit_master.sv
// vram_blit_master: fill/copy blitter mastering the SRAM arbiter v_ port.
// Define VRAM_BLIT_TIMEOUT_EN to build the ACK watchdog and err flag.
module vram_blit_master
  import vram_blit_pkg::*;
#(
  parameter int READ_WAIT      = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk_50mhz,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   mode,
  input  logic [VRAM_ADDR_W-1:0] dst_addr,
  input  logic [VRAM_ADDR_W-1:0] src_addr,
  input  logic [VRAM_ADDR_W-1:0] len,
  input  logic [PIX_W-1:0]       fill_data,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   m_stb,
  output logic                   m_we,
  output logic [VRAM_ADDR_W-1:0] m_addra,
  output logic [BUS_DATA_W-1:0]  m_dina,
  input  logic [BUS_DATA_W-1:0]  m_douta,
  input  logic                   m_ACK
);

  localparam logic [3:0] RW_LAST = 4'(READ_WAIT - 1);

  blit_state_t            state;
  logic                   mode_q;
  logic [PIX_W-1:0]       fill_q;
  logic [3:0]             wait_cnt;
  logic                   ag_load;
  logic                   ag_step;
  logic                   last;
  logic [VRAM_ADDR_W-1:0] dst;
  logic [VRAM_ADDR_W-1:0] src_nxt;
  logic [VRAM_ADDR_W-1:0] dst_nxt;
  logic                   tmo_hit;
  logic                   unused_rd_hi;

  assign ag_load      = (state == ST_IDLE) && start;
  assign ag_step      = (state == ST_NEXT);
  assign unused_rd_hi = ^m_douta[BUS_DATA_W-1:PIX_W];

  blit_addr_gen u_addr_gen (
    .clk_50mhz (clk_50mhz),
    .rst       (rst),
    .load      (ag_load),
    .step      (ag_step),
    .src_in    (src_addr),
    .dst_in    (dst_addr),
    .len_in    (len),
    .dst       (dst),
    .src_nxt   (src_nxt),
    .dst_nxt   (dst_nxt),
    .last      (last)
  );

`ifdef VRAM_BLIT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;
  blit_state_t   tmo_state;

  // count cycles spent in the current wait state; restart on entry
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      tmo_cnt   <= '0;
      tmo_state <= ST_IDLE;
    end else begin
      tmo_state <= state;
      if (state != tmo_state)
        tmo_cnt <= TW'(1);
      else if (!tmo_hit)
        tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  assign tmo_hit = (state inside {ST_RD_REQ, ST_WR_LOW, ST_WR_HIGH})
                && (state == tmo_state)
                && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // sticky timeout flag, cleared by the next accepted command
  always_ff @(posedge clk_50mhz) begin
    if (rst)
      err <= 1'b0;
    else if (ag_load)
      err <= 1'b0;
    else if (tmo_hit)
      err <= 1'b1;
  end
`else
  localparam int UNUSED_TMO_LIMIT = TIMEOUT_CYCLES;

  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  // transfer sequencer; every bus output is registered here
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      state    <= ST_IDLE;
      m_stb    <= 1'b0;
      m_we     <= 1'b0;
      m_addra  <= '0;
      m_dina   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mode_q   <= MODE_FILL;
      fill_q   <= '0;
      wait_cnt <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          m_stb <= 1'b0;
          m_we  <= 1'b0;
          if (start) begin
            mode_q <= mode;
            fill_q <= fill_data;
            busy   <= 1'b1;
            if (len == '0) begin
              state <= ST_DONE;
            end else if (mode == MODE_COPY) begin
              state    <= ST_RD_REQ;
              m_stb    <= 1'b1;
              m_addra  <= src_addr;
              wait_cnt <= '0;
            end else begin
              state   <= ST_WR_REQ;
              m_stb   <= 1'b1;
              m_we    <= 1'b1;
              m_addra <= dst_addr;
              m_dina  <= pack_pix(fill_data);
            end
          end
        end
        ST_RD_REQ: begin
          if (tmo_hit) begin
            m_stb <= 1'b0;
            m_we  <= 1'b0;
            state <= ST_DONE;
          end else if (wait_cnt != RW_LAST) begin
            wait_cnt <= wait_cnt + 4'd1;
          end else if (m_ACK) begin
            state   <= ST_WR_REQ;
            m_we    <= 1'b1;
            m_addra <= dst;
            m_dina  <= pack_pix(m_douta[PIX_W-1:0]);
          end
        end
        ST_WR_REQ: begin
          state <= ST_WR_LOW;
        end
        ST_WR_LOW: begin
          if (tmo_hit) begin
            m_stb <= 1'b0;
            m_we  <= 1'b0;
            state <= ST_DONE;
          end else if (!m_ACK) begin
            state <= ST_WR_HIGH;
          end
        end
        ST_WR_HIGH: begin
          if (tmo_hit) begin
            m_stb <= 1'b0;
            m_we  <= 1'b0;
            state <= ST_DONE;
          end else if (m_ACK) begin
            m_stb <= 1'b0;
            m_we  <= 1'b0;
            state <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (last) begin
            state <= ST_DONE;
          end else if (mode_q == MODE_COPY) begin
            state    <= ST_RD_REQ;
            m_stb    <= 1'b1;
            m_addra  <= src_nxt;
            wait_cnt <= '0;
          end else begin
            state   <= ST_WR_REQ;
            m_stb   <= 1'b1;
            m_we    <= 1'b1;
            m_addra <= dst_nxt;
            m_dina  <= pack_pix(fill_q);
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          m_stb <= 1'b0;
          m_we  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
